// File: rtl/video_pattern_source.sv
`default_nettype none
// ============================================================================
//  Module   : video_pattern_source
//  Purpose  : Avalon-ST video packet source for a 12-bit RGB444 pixel stream.
//             Emits complete IMG_WIDTH x IMG_HEIGHT frames in raster order,
//             with sop/eop framing. Downstream backpressure is honoured, and
//             an idle gap of GAP_CYCLES is inserted between frames.
//  Ports    : clk, rst_n          - clock, asynchronous active-low reset
//             enable              - level request for continuous frames
//             pattern_sel[1:0]    - 0 grey, 1 colour bars, 2 ramp, 3 checker
//             ready_in            - downstream ready (readyLatency 0)
//             valid_out, startofpacket_out, endofpacket_out, data_out[11:0]
//             frame_done          - one-cycle pulse after the eop transfer
//             frame_count[7:0]    - completed frames, wraps 255 -> 0
//  Revision : 1.0 - initial release
// ============================================================================
module video_pattern_source #(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240,
  parameter int GAP_CYCLES = 16,
  parameter int BAR_W      = 40
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic        ready_in,
  output logic        valid_out,
  output logic        startofpacket_out,
  output logic        endofpacket_out,
  output logic [11:0] data_out,
  output logic        frame_done,
  output logic [7:0]  frame_count
);

  localparam int XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int BW = (BAR_W      > 1) ? $clog2(BAR_W)      : 1;
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [XW-1:0] c_x_last   = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] c_y_last   = YW'(IMG_HEIGHT - 1);
  localparam logic [BW-1:0] c_bar_last = BW'(BAR_W - 1);
  localparam logic [GW-1:0] c_gap_load = GW'(GAP_CYCLES);

  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_stream = 2'd1;
  localparam logic [1:0] c_st_gap    = 2'd2;

  logic [1:0]    r_state, w_nstate;
  logic [XW-1:0] r_x, w_nx;
  logic [YW-1:0] r_y, w_ny;
  logic [BW-1:0] r_bcnt, w_nbcnt;   // pixel position inside the current bar
  logic [2:0]    r_bidx, w_nbidx;   // colour bar index
  logic [1:0]    r_pat, w_npat;
  logic [GW-1:0] r_gap, w_ngap;

  logic          w_last;
  logic          w_start;
  logic          w_eop_xfer;
  logic [3:0]    w_level;
  logic          w_cx;
  logic          w_cy;
  logic [11:0]   w_pix;
  logic          w_nvalid;

  // Next-state and next-position logic. Outputs are registered from the
  // next-position values so the presented pixel always matches (x, y).
  always_comb begin
    w_last     = (r_x == c_x_last) && (r_y == c_y_last);
    w_eop_xfer = (r_state == c_st_stream) && ready_in && w_last;
    w_start    = 1'b0;
    w_nstate   = r_state;
    w_nx       = r_x;
    w_ny       = r_y;
    w_nbcnt    = r_bcnt;
    w_nbidx    = r_bidx;
    w_npat     = r_pat;
    w_ngap     = r_gap;

    case (r_state)
      c_st_idle: begin
        w_start = enable;
      end
      c_st_stream: begin
        if (ready_in) begin
          if (w_last) begin
            if (GAP_CYCLES == 0) begin
              // No gap: the gap-exit decision is taken at the eop edge.
              w_start  = enable;
              w_nstate = c_st_idle;
            end else begin
              w_nstate = c_st_gap;
              w_ngap   = c_gap_load;
            end
          end else if (r_x == c_x_last) begin
            w_nx    = '0;
            w_ny    = r_y + YW'(1);
            w_nbcnt = '0;
            w_nbidx = 3'd0;
          end else begin
            w_nx = r_x + XW'(1);
            if (r_bcnt == c_bar_last) begin
              w_nbcnt = '0;
              w_nbidx = r_bidx + 3'd1;
            end else begin
              w_nbcnt = r_bcnt + BW'(1);
            end
          end
        end
      end
      c_st_gap: begin
        // Counter was loaded with GAP_CYCLES; leaving on the edge where it
        // reads 1 keeps valid_out low for exactly GAP_CYCLES cycles.
        if (r_gap <= GW'(1)) begin
          w_start  = enable;
          w_nstate = c_st_idle;
        end else begin
          w_ngap = r_gap - GW'(1);
        end
      end
      default: begin
        w_nstate = c_st_idle;
      end
    endcase

    if (w_start) begin
      w_nstate = c_st_stream;
      w_nx     = '0;
      w_ny     = '0;
      w_nbcnt  = '0;
      w_nbidx  = 3'd0;
      w_npat   = pattern_sel;
    end
  end

  // Pixel generator driven by the next presented position.
  always_comb begin
    w_level  = 4'(w_nx >> 4);
    w_cx     = 1'(w_nx >> 3);
    w_cy     = 1'(w_ny >> 3);
    w_nvalid = (w_nstate == c_st_stream);
    case (w_npat)
      2'd0: w_pix = 12'h56A;
      2'd1: begin
        case (w_nbidx)
          3'd0:    w_pix = 12'hFFF;
          3'd1:    w_pix = 12'hFF0;
          3'd2:    w_pix = 12'h0FF;
          3'd3:    w_pix = 12'h0F0;
          3'd4:    w_pix = 12'hF0F;
          3'd5:    w_pix = 12'hF00;
          3'd6:    w_pix = 12'h00F;
          default: w_pix = 12'h000;
        endcase
      end
      2'd2:    w_pix = {w_level, w_level, w_level};
      default: w_pix = (w_cx ^ w_cy) ? 12'hFFF : 12'h000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state           <= c_st_idle;
      r_x               <= '0;
      r_y               <= '0;
      r_bcnt            <= '0;
      r_bidx            <= 3'd0;
      r_pat             <= 2'd0;
      r_gap             <= '0;
      valid_out         <= 1'b0;
      startofpacket_out <= 1'b0;
      endofpacket_out   <= 1'b0;
      data_out          <= 12'h000;
      frame_done        <= 1'b0;
      frame_count       <= 8'd0;
    end else begin
      r_state           <= w_nstate;
      r_x               <= w_nx;
      r_y               <= w_ny;
      r_bcnt            <= w_nbcnt;
      r_bidx            <= w_nbidx;
      r_pat             <= w_npat;
      r_gap             <= w_ngap;
      valid_out         <= w_nvalid;
      startofpacket_out <= w_nvalid && (w_nx == '0) && (w_ny == '0);
      endofpacket_out   <= w_nvalid && (w_nx == c_x_last) && (w_ny == c_y_last);
      data_out          <= w_nvalid ? w_pix : 12'h000;
      frame_done        <= w_eop_xfer;
      if (w_eop_xfer) begin
        frame_count <= frame_count + 8'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_video_pattern_source.sv
`default_nettype none
// ============================================================================
//  Module   : tb_video_pattern_source
//  Purpose  : Self-checking bench for video_pattern_source. A reference model
//             derives every expected pixel from the frame transfer index, and
//             a table of (pattern, x, y, value) records spot-checks captured
//             frames. A second instance with GAP_CYCLES = 0 covers
//             back-to-back frames.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_video_pattern_source;

  localparam int W   = 64;
  localparam int H   = 12;
  localparam int GAP = 4;
  localparam int BAR = 8;
  localparam int N   = W * H;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic        ready_in = 1'b1;
  logic        valid_out, sop, eop, frame_done;
  logic [11:0] data_out;
  logic [7:0]  frame_count;

  logic        en_b = 1'b1;
  logic        rdy_b = 1'b1;
  logic [1:0]  sel_b = 2'd1;
  logic        b_valid, b_sop, b_eop, b_done;
  logic [11:0] b_data;
  logic [7:0]  b_count;

  always #5 clk = ~clk;

  video_pattern_source #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .GAP_CYCLES(GAP), .BAR_W(BAR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pattern_sel(pattern_sel),
    .ready_in(ready_in), .valid_out(valid_out), .startofpacket_out(sop),
    .endofpacket_out(eop), .data_out(data_out), .frame_done(frame_done),
    .frame_count(frame_count)
  );

  video_pattern_source #(
    .IMG_WIDTH(16), .IMG_HEIGHT(2), .GAP_CYCLES(0), .BAR_W(2)
  ) dut_nogap (
    .clk(clk), .rst_n(rst_n), .enable(en_b), .pattern_sel(sel_b),
    .ready_in(rdy_b), .valid_out(b_valid), .startofpacket_out(b_sop),
    .endofpacket_out(b_eop), .data_out(b_data), .frame_done(b_done),
    .frame_count(b_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference pixel from the pattern rules using plain arithmetic.
  function automatic logic [11:0] ref_pix(input int pat, input int x, input int y);
    int lvl;
    case (pat)
      0: return 12'h56A;
      1: begin
        case ((x / BAR) % 8)
          0: return 12'hFFF;
          1: return 12'hFF0;
          2: return 12'h0FF;
          3: return 12'h0F0;
          4: return 12'hF0F;
          5: return 12'hF00;
          6: return 12'h00F;
          default: return 12'h000;
        endcase
      end
      2: begin
        lvl = (x / 16) % 16;
        return 12'(lvl * 12'h111);
      end
      default: return (((x / 8) % 2) != ((y / 8) % 2)) ? 12'hFFF : 12'h000;
    endcase
  endfunction

  // ---------------- reference model / monitor -------------------------------
  int          m_k = 0, m_frames = 0, m_total = 0, m_pat = 0;
  int          m_sops = 0, m_eops = 0, m_dones = 0;
  int          last_gap = -1, gap_run = 0;
  logic        in_gap = 1'b0, exp_done = 1'b0;
  logic        p_valid = 1'b0, p_ready = 1'b0, p_sop = 1'b0, p_eop = 1'b0;
  logic [11:0] p_data = 12'h000;
  logic [1:0]  p_sel = 2'd0;
  logic [11:0] cap [H][W];

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_outputs", {8'd0, valid_out, sop, eop, frame_done, frame_count, data_out}, 32'd0);
      m_k = 0; m_frames = 0; exp_done = 1'b0; in_gap = 1'b0;
    end else begin
      if (p_valid && !p_ready)
        chk("stall_hold", {valid_out, sop, eop, data_out}, {p_valid, p_sop, p_eop, p_data});
      chk("frame_done", frame_done, exp_done);
      chk("frame_count", frame_count, m_frames[7:0]);
      exp_done = 1'b0;
      if (frame_done) m_dones++;
      if (valid_out) begin
        if (!p_valid) begin
          m_pat = int'(p_sel);
          if (in_gap) last_gap = gap_run;
          in_gap = 1'b0;
        end
        chk("pixel", data_out, ref_pix(m_pat, m_k % W, m_k / W));
        chk("sop", sop, m_k == 0);
        chk("eop", eop, m_k == N - 1);
        if (ready_in) begin
          cap[m_k / W][m_k % W] = data_out;
          m_total++;
          if (sop) m_sops++;
          if (eop) m_eops++;
          m_k++;
          if (m_k == N) begin
            m_k = 0; m_frames++; exp_done = 1'b1; in_gap = 1'b1; gap_run = 0;
          end
        end
      end else if (in_gap) begin
        gap_run++;
      end
    end
    p_valid = valid_out; p_ready = ready_in; p_sop = sop; p_eop = eop;
    p_data = data_out; p_sel = pattern_sel;
  end

  // ---------------- ready driver --------------------------------------------
  int rmode = 0;
  int cyc = 0;
  always @(posedge clk) begin
    #1;
    cyc++;
    case (rmode)
      0:       ready_in = 1'b1;
      1:       ready_in = (cyc % 10) < 5;
      default: ready_in = 1'($urandom_range(0, 1));
    endcase
  end

  // ---------------- spot-check table ----------------------------------------
  typedef struct {
    int          pat;
    int          x;
    int          y;
    logic [11:0] exp;
  } vec_t;
  vec_t tbl [18];

  task automatic check_table(input int pat);
    for (int i = 0; i < 18; i++) begin
      if (tbl[i].pat == pat)
        chk($sformatf("tbl_p%0d_x%0d_y%0d", pat, tbl[i].x, tbl[i].y),
            cap[tbl[i].y][tbl[i].x], tbl[i].exp);
    end
  endtask

  task automatic wait_frames(input int target, input int budget);
    int c = 0;
    while (m_frames < target && c < budget) begin
      @(posedge clk); #1; c++;
    end
    if (m_frames < target) chk("frame_timeout", m_frames, target);
    @(negedge clk); #1;
  endtask

  task automatic wait_xfers(input int target, input int budget);
    int c = 0;
    while (m_total < target && c < budget) begin
      @(posedge clk); #1; c++;
    end
    if (m_total < target) chk("xfer_timeout", m_total, target);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence -------------------------------------------
  initial begin
    int base;
    int c;
    tbl[0]  = '{0,  0,  0, 12'h56A};
    tbl[1]  = '{0, 63, 11, 12'h56A};
    tbl[2]  = '{1,  0,  0, 12'hFFF};
    tbl[3]  = '{1,  7,  0, 12'hFFF};
    tbl[4]  = '{1,  8,  0, 12'hFF0};
    tbl[5]  = '{1, 55,  0, 12'h00F};
    tbl[6]  = '{1, 56,  0, 12'h000};
    tbl[7]  = '{1, 63,  0, 12'h000};
    tbl[8]  = '{1,  0, 11, 12'hFFF};
    tbl[9]  = '{1,  8, 11, 12'hFF0};
    tbl[10] = '{1, 63, 11, 12'h000};
    tbl[11] = '{2, 37,  5, 12'h222};
    tbl[12] = '{2, 63,  0, 12'h333};
    tbl[13] = '{2, 15,  3, 12'h000};
    tbl[14] = '{3,  8,  0, 12'hFFF};
    tbl[15] = '{3,  8,  8, 12'h000};
    tbl[16] = '{3,  0,  8, 12'hFFF};
    tbl[17] = '{3,  0,  0, 12'h000};

    // Reset held with enable high.
    rst_n = 1'b0; enable = 1'b1; pattern_sel = 2'd0; rmode = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", valid_out, 0);
    chk("rst_count", frame_count, 0);
    #2 rst_n = 1'b1;
    #1 chk("release_valid_no_edge", valid_out, 0);
    @(posedge clk); #1;
    chk("first_valid", valid_out, 1);
    chk("first_sop", sop, 1);
    chk("first_data", data_out, 12'h56A);

    // Zero-gap instance: next frame's sop directly follows the eop transfer.
    c = 0;
    while (!b_eop && c < 100) begin
      @(posedge clk); #1; c++;
    end
    chk("nogap_eop_seen", b_eop, 1);
    chk("nogap_eop_data", b_data, 12'h000);
    @(posedge clk); #1;
    chk("nogap_valid", b_valid, 1);
    chk("nogap_sop", b_sop, 1);
    chk("nogap_data", b_data, 12'hFFF);
    chk("nogap_done", b_done, 1);
    chk("nogap_count", b_count, 1);
    @(posedge clk); #1;
    chk("nogap_done_pulse", b_done, 0);
    chk("nogap_sop_drop", {b_valid, b_sop}, 2'b10);

    // Two frames of solid grey.
    wait_frames(2, 3000);
    chk("p0_sops", m_sops, 2);
    chk("p0_eops", m_eops, 2);
    chk("p0_dones", m_dones, 2);
    chk("p0_count", frame_count, 2);
    check_table(0);

    // Colour bars; a mid-frame selector change must be ignored.
    pattern_sel = 2'd1;
    wait_xfers(m_total + 100, 2000);
    chk("gap_len", last_gap, GAP);
    pattern_sel = 2'd2;
    wait_frames(3, 2000);
    check_table(1);

    // Grey ramp under periodic backpressure.
    rmode = 1;
    base = m_total;
    wait_frames(4, 4000);
    check_table(2);
    chk("bp_xfers", m_total - base, N);

    // Checkerboard with random ready; enable dropped mid-frame.
    pattern_sel = 2'd3; rmode = 2;
    base = m_total;
    wait_xfers(base + 100, 2000);
    enable = 1'b0;
    wait_frames(5, 4000);
    check_table(3);
    chk("p3_eops", m_eops, 5);
    chk("p3_xfers", m_total - base, N);
    repeat (GAP + 20) begin
      @(posedge clk); #1;
      chk("idle_valid", valid_out, 0);
    end
    chk("idle_count", frame_count, 5);

    // Asynchronous reset pulse mid-frame, between clock edges.
    enable = 1'b1; pattern_sel = 2'd1; rmode = 1;
    base = m_total;
    wait_xfers(base + 50, 2000);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_outputs", {valid_out, sop, eop, frame_done, data_out}, 16'd0);
    chk("async_rst_count", frame_count, 0);
    m_k = 0; m_frames = 0; exp_done = 1'b0; in_gap = 1'b0; m_dones = 0;
    p_valid = 1'b0; p_ready = 1'b0;
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("restart_valid", valid_out, 1);
    chk("restart_sop", sop, 1);
    chk("restart_data", data_out, 12'hFFF);
    wait_frames(1, 4000);
    chk("restart_count", frame_count, 1);
    chk("restart_dones", m_dones, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/video_pattern_source.md
Name: video_pattern_source

Overview:
- Avalon-ST video packet source for the 12-bit RGB444 pixel stream consumed by the filter blocks (blurring, etc.).
- Generates complete IMG_WIDTH x IMG_HEIGHT frames, raster order, with startofpacket/endofpacket framing, and honours downstream backpressure.
- Used as the upstream driver in block benches and as an on-chip test pattern generator in place of the camera path.

Parameters:
IMG_WIDTH, 320, pixels per line
IMG_HEIGHT, 240, lines per frame
GAP_CYCLES, 16, idle cycles between the eop transfer and the next sop; 0 allowed
BAR_W, 40, colour bar width in pixels (IMG_WIDTH/8)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
enable  in  1  level; request continuous frame generation
pattern_sel  in  2  0 solid grey, 1 colour bars, 2 grey ramp, 3 checkerboard
ready_in  in  1  downstream ready (readyLatency 0)
valid_out  out  1  data_out/sop/eop valid
startofpacket_out  out  1  first pixel of frame
endofpacket_out  out  1  last pixel of frame
data_out  out  12  pixel {R[3:0],G[3:0],B[3:0]}
frame_done  out  1  one-cycle pulse after eop transfer
frame_count  out  8  completed frames, wraps 255->0

Behaviour:
- Reset, async, all outputs immediately 0. FSM = IDLE, x = y = 0, frame_count = 0, gap counter = 0.
- Transfer = rising edge with valid_out && ready_in. All outputs are registered.
- While valid_out && !ready_in, valid_out, data_out, sop and eop hold stable. No pixel is dropped or duplicated.
- FSM IDLE:
  - valid_out = 0.
  - At an edge with enable = 1: latch pattern_sel, set x = y = 0, go to STREAM.
  - valid_out = 1 and sop = 1 are presented right after that same edge.
- FSM STREAM:
  - valid_out = 1.
  - startofpacket_out = (x == 0 && y == 0).
  - endofpacket_out = (x == IMG_WIDTH-1 && y == IMG_HEIGHT-1).
  - On each transfer, x increments. At x == IMG_WIDTH-1, x wraps to 0 and y increments.
  - On the eop transfer: frame_done = 1 for exactly the next cycle, frame_count increments, valid_out drops, go to GAP loading GAP_CYCLES.
  - If GAP_CYCLES == 0, the GAP-exit decision below is applied directly at the eop edge.
- FSM GAP:
  - valid_out = 0; decrement the gap counter each cycle.
  - valid_out stays low for exactly GAP_CYCLES cycles.
  - Exit: if enable = 1, relatch pattern_sel and go to STREAM (sop at x = y = 0). Otherwise go to IDLE.
- enable low mid-frame does not truncate: the frame runs to eop, then the FSM passes through GAP to IDLE.
- pattern_sel changes mid-frame are ignored until the next frame start.
- Pixel value, computed from the (x, y) being presented, using the latched pattern:
  - 0 (solid grey): 12'h56A.
  - 1 (colour bars): bar index b increments every BAR_W pixels via a counter, no divider. b = 0..7 maps to FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
  - 2 (grey ramp): L = (x>>4) mod 16; data = {L, L, L}.
  - 3 (checkerboard): (x[3] ^ y[3]) ? FFF : 000.
- ready_in is don't-care while valid_out = 0.
- A reset asserted mid-frame abandons the frame (no eop). After release, the next frame starts with sop.

Test Plan:
- Reset: hold rst_n = 0 with enable = 1 -> all outputs 0; valid_out stays 0 until the first edge after release with enable = 1.
- Pattern 0, ready_in = 1, GAP_CYCLES = 16, enable = 1 for 2 frames -> exactly 76800 transfers per frame, all 12'h56A. Exactly one sop (first) and one eop (76800th) per frame. frame_done pulses once. frame_count goes 1 then 2. valid_out low for exactly 16 cycles between frames.
- Pattern 1, ready_in = 1 -> line 0 values: x = 0 FFF, x = 39 FFF, x = 40 FF0, x = 279 00F, x = 280 000, x = 319 000. Line 239 matches line 0.
- Backpressure, pattern 2: ready_in low for 5 cycles every 10 cycles -> outputs stable during stalls. Received pixel at (x = 37, y = 5) = 12'h222, (x = 300, y = 0) = 12'h222. Total transfers = 76800.
- Pattern 3, drop enable at transfer 1000 -> frame completes with eop at transfer 76800. (8, 0) = FFF, (8, 8) = 000, (0, 8) = FFF. After 16 gap cycles the FSM is in IDLE with valid_out = 0 indefinitely.
- Async reset pulse (no clock edge) at transfer 500 -> valid_out and all outputs 0 immediately, frame_count = 0. Re-enable -> first transfer has sop = 1 and pixel (0, 0).
